// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit front end to a word-wide data memory.
// Sub-word stores use a read-modify-write sequence; bad requests get a single-cycle error response.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] DMEM_LIMIT = 32'h0000_2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  state_t                  state_q, state_d;
  logic                    we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d, rdata_q, rdata_d;
  logic [4:0]              sh;
  logic [DATA_WIDTH-1:0]   shifted, lane, ext, merged;
  logic                    req_err;
  always_comb begin
    sh      = {addr_q[1:0], 3'b000};
    shifted = mem_dout >> sh;
    lane    = (size_q == 2'b00) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF);
    ext     = (size_q == 2'b00) ? {{(DATA_WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]} :
              (size_q == 2'b01) ? {{(DATA_WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]} :
              mem_dout;
    // din_q still holds the store data from accept; splice its low field into the read word
    merged  = (mem_dout & ~(lane << sh)) | ((din_q & lane) << sh);
    req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
              (req_addr < DMEM_BASE) || (req_addr >= DMEM_LIMIT);
  end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        uns_d   = req_unsigned;
        err_d   = req_err;
        size_d  = req_size;
        addr_d  = req_addr;
        din_d   = req_wdata;
        rdata_d = req_err ? '0 : rdata_q;
        state_d = req_err ? RESP : (req_we && req_size == 2'b10) ? WR : RD;
      end
      RD:   state_d = CAP;
      CAP: begin
        din_d   = we_q ? merged : din_q;
        rdata_d = we_q ? rdata_q : ext;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;
  assign mem_rd_en = state_q == RD;
  assign mem_wr_en = state_q == WR;
  assign mem_addr  = (mem_rd_en | mem_wr_en) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_din   = mem_wr_en ? din_q : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of lsu_mem_ctrl against a small word memory.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [31:0] mem [16];
  int          checks = 0, failures = 0;
  int          cyc = 0, rd_n = 0, wr_n = 0, rsp_n = 0, acc_n = 0, viol = 0;
  logic [31:0] rd_addr, wr_addr, wr_din;
  int          acc_cyc [4];
  int          rsp_cyc [4];
  logic [31:0] rsp_dat [4];
  logic [31:0] rd;
  logic        er;
  int          lat;

  lsu_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_dout <= mem[mem_addr[5:2]];
    if (mem_wr_en) mem[mem_addr[5:2]] = mem_din;
    if (req_valid && req_ready && !reset) begin
      if (acc_n < 4) acc_cyc[acc_n] = cyc;
      acc_n++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (mem_rd_en) begin rd_n++; rd_addr = mem_addr; end
    if (mem_wr_en) begin wr_n++; wr_addr = mem_addr; wr_din = mem_din; end
    if (rsp_valid) begin
      if (rsp_n < 4) begin rsp_cyc[rsp_n] = cyc; rsp_dat[rsp_n] = rsp_rdata; end
      rsp_n++;
    end
    if (mem_rd_en && mem_wr_en) viol++;
    if (!mem_rd_en && !mem_wr_en && (mem_addr != 0 || mem_din != 0)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] r, output logic e, output int l);
    int w;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    rd_n = 0; wr_n = 0; rsp_n = 0;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check("ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    l = 0; r = 'x; e = 1'bx;
    for (int i = 0; i < 10; i++) begin
      l++;
      if (rsp_valid) begin r = rsp_rdata; e = rsp_err; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_dout = '0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp", {29'b0, rsp_valid, rsp_err, mem_rd_en | mem_wr_en}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_din", mem_din, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, rd, er, lat);
    check("sw_lat", lat, 2);
    check("sw_err", {31'b0, er}, 0);
    check("sw_rdata", rd, 0);
    check("sw_nwr", wr_n, 1);
    check("sw_nrd", rd_n, 0);
    check("sw_waddr", wr_addr, 32'h1004);
    check("sw_wdin", wr_din, 32'hDEADBEEF);

    mem[0] = 32'h80FF7F01;
    run(1'b0, 2'b00, 1'b0, 32'h1003, 0, rd, er, lat);
    check("lb_data", rd, 32'hFFFFFF80);
    check("lb_lat", lat, 3);
    check("lb_nrd", rd_n, 1);
    check("lb_raddr", rd_addr, 32'h1000);
    run(1'b0, 2'b00, 1'b1, 32'h1001, 0, rd, er, lat);
    check("lbu_data", rd, 32'h0000007F);
    check("lbu_lat", lat, 3);
    run(1'b0, 2'b01, 1'b0, 32'h1002, 0, rd, er, lat);
    check("lh_data", rd, 32'hFFFF80FF);
    check("lh_nrd", rd_n, 1);
    check("lh_raddr", rd_addr, 32'h1000);
    run(1'b0, 2'b01, 1'b1, 32'h1002, 0, rd, er, lat);
    check("lhu_data", rd, 32'h000080FF);
    run(1'b0, 2'b10, 1'b0, 32'h1000, 0, rd, er, lat);
    check("lw_data", rd, 32'h80FF7F01);
    check("lw_err", {31'b0, er}, 0);
    @(negedge clk);
    check("rdata_hold", rsp_rdata, 32'h80FF7F01);

    mem[0] = 32'h11223344;
    run(1'b1, 2'b00, 1'b0, 32'h1001, 32'h123456AB, rd, er, lat);
    check("sb_lat", lat, 4);
    check("sb_nrd", rd_n, 1);
    check("sb_raddr", rd_addr, 32'h1000);
    check("sb_nwr", wr_n, 1);
    check("sb_waddr", wr_addr, 32'h1000);
    check("sb_wdin", wr_din, 32'h1122AB44);
    check("sb_rdata", rd, 0);
    mem[0] = 32'h11223344;
    run(1'b1, 2'b01, 1'b0, 32'h1002, 32'hFFFFBEEF, rd, er, lat);
    check("sh_lat", lat, 4);
    check("sh_wdin", wr_din, 32'hBEEF3344);

    run(1'b0, 2'b10, 1'b0, 32'h1002, 0, rd, er, lat);
    check("lwmis_err", {31'b0, er}, 1);
    check("lwmis_lat", lat, 1);
    check("lwmis_rdata", rd, 0);
    check("lwmis_mem", rd_n + wr_n, 0);
    run(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h55555555, rd, er, lat);
    check("swlow_err", {31'b0, er}, 1);
    check("swlow_lat", lat, 1);
    check("swlow_mem", rd_n + wr_n, 0);
    run(1'b0, 2'b00, 1'b0, 32'h2000, 0, rd, er, lat);
    check("lblim_err", {31'b0, er}, 1);
    run(1'b0, 2'b11, 1'b0, 32'h1000, 0, rd, er, lat);
    check("sz11_err", {31'b0, er}, 1);
    check("sz11_mem", rd_n + wr_n, 0);
    run(1'b1, 2'b01, 1'b0, 32'h1001, 32'h1234, rd, er, lat);
    check("shmis_err", {31'b0, er}, 1);
    mem[15] = 32'h12345678;
    run(1'b0, 2'b00, 1'b1, 32'h1FFF, 0, rd, er, lat);
    check("lbtop_err", {31'b0, er}, 0);
    check("lbtop_data", rd, 32'h00000012);

    mem[0] = 32'h11223344;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h1001; req_wdata = 32'hAB;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    wr_n = 0; rsp_n = 0;
    reset = 1'b1;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_wr", {31'b0, mem_wr_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_nwr", wr_n, 0);
    check("abort_nrsp", rsp_n, 0);
    check("abort_mem", mem[0], 32'h11223344);
    check("abort_idle", {31'b0, req_ready}, 32'd1);

    mem[1] = 32'h0A0B0C0D;
    mem[2] = 32'h55667788;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h1004; req_valid = 1'b1;
    acc_n = 0; rsp_n = 0;
    @(negedge clk);
    req_addr = 32'h1008;
    for (int i = 0; i < 30 && rsp_n < 2; i++) @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_nacc", {31'b0, acc_n >= 2}, 32'd1);
    check("b2b_nrsp", {31'b0, rsp_n >= 2}, 32'd1);
    check("b2b_lat0", rsp_cyc[0] - acc_cyc[0], 3);
    check("b2b_gap", acc_cyc[1] - rsp_cyc[0], 1);
    check("b2b_lat1", rsp_cyc[1] - acc_cyc[1], 3);
    check("b2b_d0", rsp_dat[0], 32'h0A0B0C0D);
    check("b2b_d1", rsp_dat[1], 32'h55667788);
    check("excl_zero", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
